// File: rtl/mismatch_monitor.sv
// mismatch_monitor: checker lock, windowed error budget and sticky halt.
// Optional loss-of-lock path is built when MISMATCH_MON_LOL_EN is defined.
module mismatch_monitor #(
  parameter int VALID_LATENCY = 3,
  parameter int LOCK_WORDS    = 64,
  parameter int WIN_LOG2      = 10,
  parameter int ERR_THRESH    = 16,
  parameter int CNT_W         = 16,
  parameter int LOL_RUN       = 8
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic             din_valid,
  input  logic             mismatch,
  output logic             locked,
  output logic             halt,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] err_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [7:0]       lol_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    HALTED  = 2'd3
  } st_t;

  localparam int RUN_W = $clog2(LOCK_WORDS + 1);
  localparam int WE_W  = WIN_LOG2 + 1;

  st_t                      st;
  logic [VALID_LATENCY-1:0] dly;
  logic [RUN_W-1:0]         run;
  logic [WIN_LOG2-1:0]      win_cnt;
  logic [WE_W-1:0]          win_err;
  logic                     chk;
  logic                     err;
  logic                     win_last;
  logic                     thr_hit;
  logic                     lock_hit;
  logic                     lol_hit;

  assign state    = st;
  assign chk      = dly[VALID_LATENCY-1];
  assign err      = chk & mismatch;
  assign win_last = chk & (&win_cnt);
  assign thr_hit  = err &
    ((win_err + WE_W'(1)) >= WE_W'(ERR_THRESH));
  assign lock_hit = chk & ~mismatch &
    ((run + RUN_W'(1)) == RUN_W'(LOCK_WORDS));

`ifdef MISMATCH_MON_LOL_EN
  localparam int LR_W = $clog2(LOL_RUN + 1);

  logic [LR_W-1:0] lol_run;

  assign lol_hit = err &
    ((lol_run + LR_W'(1)) == LR_W'(LOL_RUN));

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      lol_run <= '0;
      lol_cnt <= '0;
    end else if (clear) begin
      lol_run <= '0;
      lol_cnt <= '0;
    end else if (st != LOCKED || !enable) begin
      lol_run <= '0;
    end else if (lol_hit && !thr_hit) begin
      lol_run <= '0;
      lol_cnt <= (&lol_cnt) ? lol_cnt : lol_cnt + 8'd1;
    end else if (err) begin
      lol_run <= lol_run + LR_W'(1);
    end else if (chk) begin
      lol_run <= '0;
    end
  end
`else
  assign lol_hit = 1'b0;
  assign lol_cnt = '0;
`endif

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      dly      <= '0;
      st       <= IDLE;
      locked   <= 1'b0;
      halt     <= 1'b0;
      run      <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
      err_cnt  <= '0;
      word_cnt <= '0;
    end else begin
      dly <= VALID_LATENCY'({dly, din_valid});
      if (clear) begin
        st       <= enable ? ACQUIRE : IDLE;
        locked   <= 1'b0;
        halt     <= 1'b0;
        run      <= '0;
        win_cnt  <= '0;
        win_err  <= '0;
        err_cnt  <= '0;
        word_cnt <= '0;
      end else if (st == HALTED) begin
        halt <= 1'b1;
      end else if (!enable) begin
        st      <= IDLE;
        locked  <= 1'b0;
        run     <= '0;
        win_cnt <= '0;
        win_err <= '0;
      end else begin
        unique case (1'b1)
          (st == IDLE): st <= ACQUIRE;
          (st == ACQUIRE): begin
            if (lock_hit) begin
              st     <= LOCKED;
              locked <= 1'b1;
              run    <= '0;
            end else if (err) begin
              run <= '0;
            end else if (chk) begin
              run <= run + RUN_W'(1);
            end
          end
          (st == LOCKED): begin
            if (chk) begin
              win_cnt  <= win_cnt + WIN_LOG2'(1);
              word_cnt <= (&word_cnt) ? word_cnt
                                      : word_cnt + CNT_W'(1);
            end
            if (err)
              err_cnt <= (&err_cnt) ? err_cnt
                                    : err_cnt + CNT_W'(1);
            // halt outranks both loss-of-lock and the window clear
            if (thr_hit) begin
              st      <= HALTED;
              locked  <= 1'b0;
              halt    <= 1'b1;
              win_err <= win_err + WE_W'(1);
            end else if (lol_hit) begin
              st      <= ACQUIRE;
              locked  <= 1'b0;
              win_cnt <= '0;
              win_err <= '0;
            end else if (win_last) begin
              win_err <= '0;
            end else if (err) begin
              win_err <= win_err + WE_W'(1);
            end
          end
          default: st <= st;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mismatch_monitor.sv
// tb_mismatch_monitor: directed and random checks against a reference model.
// Instance 0 uses defaults; instance 1 has CNT_W=4 and ERR_THRESH=1024.
module tb_mismatch_monitor;

  logic clk = 1'b0;
  logic arst_n, enable, clear, din_valid, mismatch;

  logic        locked0, halt0;
  logic [1:0]  state0;
  logic [15:0] err0, word0;
  logic [7:0]  lol0;
  logic        locked1, halt1;
  logic [1:0]  state1;
  logic [3:0]  err1, word1;
  logic [7:0]  lol1;

  int tests = 0;
  int fails = 0;

`ifdef MISMATCH_MON_LOL_EN
  localparam bit LOL_EN = 1'b1;
`else
  localparam bit LOL_EN = 1'b0;
`endif

  bit vq[$];
  int mst[2], run[2], ww[2], we[2], lr[2];
  int errs[2], words[2], lols[2];
  logic [43:0] mv0;
  logic [19:0] mv1;
  wire  [43:0] dv0 = {state0, halt0, locked0, err0, word0, lol0};
  wire  [19:0] dv1 = {state1, halt1, locked1, err1, word1, lol1};

  always #5 clk = ~clk;

  mismatch_monitor u_dut (
    .clk(clk), .arst_n(arst_n), .enable(enable), .clear(clear),
    .din_valid(din_valid), .mismatch(mismatch),
    .locked(locked0), .halt(halt0), .state(state0),
    .err_cnt(err0), .word_cnt(word0), .lol_cnt(lol0)
  );

  mismatch_monitor #(.CNT_W(4), .ERR_THRESH(1024)) u_sat (
    .clk(clk), .arst_n(arst_n), .enable(enable), .clear(clear),
    .din_valid(din_valid), .mismatch(mismatch),
    .locked(locked1), .halt(halt1), .state(state1),
    .err_cnt(err1), .word_cnt(word1), .lol_cnt(lol1)
  );

  task automatic model_pack();
    mv0 = {2'(mst[0]), mst[0] == 3, mst[0] == 2,
           16'(errs[0]), 16'(words[0]), 8'(lols[0])};
    mv1 = {2'(mst[1]), mst[1] == 3, mst[1] == 2,
           4'(errs[1]), 4'(words[1]), 8'(lols[1])};
  endtask

  task automatic model_reset();
    vq = '{1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 2; k++) begin
      mst[k] = 0; run[k] = 0; ww[k] = 0; we[k] = 0; lr[k] = 0;
      errs[k] = 0; words[k] = 0; lols[k] = 0;
    end
    model_pack();
  endtask

  task automatic model_step(input bit e, c, v, m);
    bit chk, err;
    int th, smax;
    chk = vq.pop_front();
    vq.push_back(v);
    err = chk && m;
    for (int k = 0; k < 2; k++) begin
      th   = (k == 1) ? 1024 : 16;
      smax = (k == 1) ? 15 : 65535;
      if (c) begin
        mst[k] = e ? 1 : 0;
        run[k] = 0; ww[k] = 0; we[k] = 0; lr[k] = 0;
        errs[k] = 0; words[k] = 0; lols[k] = 0;
      end else if (mst[k] == 3) begin
        mst[k] = 3;
      end else if (!e) begin
        mst[k] = 0; run[k] = 0; ww[k] = 0; we[k] = 0; lr[k] = 0;
      end else if (mst[k] == 0) begin
        mst[k] = 1;
      end else if (mst[k] == 1) begin
        if (chk) run[k] = err ? 0 : run[k] + 1;
        if (run[k] == 64) begin
          mst[k] = 2;
          run[k] = 0;
        end
      end else if (chk) begin
        if (words[k] < smax) words[k]++;
        ww[k] = (ww[k] + 1) % 1024;
        if (err) begin
          if (errs[k] < smax) errs[k]++;
          we[k]++;
          lr[k]++;
        end else begin
          lr[k] = 0;
        end
        if (err && we[k] >= th) begin
          mst[k] = 3;
        end else if (LOL_EN && lr[k] >= 8) begin
          mst[k] = 1;
          if (lols[k] < 255) lols[k]++;
          ww[k] = 0; we[k] = 0; lr[k] = 0;
        end else if (ww[k] == 0) begin
          we[k] = 0;
        end
      end
    end
    model_pack();
  endtask

  task automatic cyc(input bit e, c, v, m);
    enable = e; clear = c; din_valid = v; mismatch = m;
    @(posedge clk);
    if (!arst_n) model_reset();
    else model_step(e, c, v, m);
    @(negedge clk);
  endtask

  task automatic go_locked();
    for (int i = 0; i < 300 && mst[0] != 2; i++) cyc(1, 0, 1, 0);
  endtask

  task automatic test_reset();
    arst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 1, 1);
      tests++;
      if ({dv0, dv1} !== 64'd0) begin
        fails++;
        $display("FAIL reset_state: got %h/%h want 0", dv0, dv1);
      end
    end
    arst_n = 1'b1;
    cyc(0, 0, 0, 0);
    tests++;
    if (dv0 !== mv0 || dv1 !== mv1) begin
      fails++;
      $display("FAIL reset_release: got %h/%h want %h/%h",
               dv0, dv1, mv0, mv1);
    end
  endtask

  task automatic test_lock();
    int  w;
    bit  nchk, mm;
    w = 0;
    cyc(1, 1, 0, 0);
    for (int i = 0; i < 300 && w < 127; i++) begin
      nchk = vq[0];
      if (nchk) w++;
      mm = nchk && (w == 63);
      cyc(1, 0, 1, mm);
      tests++;
      if (locked0 !== (w >= 127)) begin
        fails++;
        $display("FAIL lock_timing: word %0d got locked=%b", w, locked0);
      end
      tests++;
      if (dv0 !== mv0 || dv1 !== mv1) begin
        fails++;
        $display("FAIL lock_model: got %h/%h want %h/%h",
                 dv0, dv1, mv0, mv1);
      end
    end
    tests++;
    if (locked0 !== 1'b1 || state0 !== 2'd2 || locked1 !== 1'b1) begin
      fails++;
      $display("FAIL lock_final: got %b/%0d want 1/2", locked0, state0);
    end
  endtask

  task automatic test_window();
    int w2, r;
    bit nchk, mm;
    w2 = 0;
    r  = $urandom_range(0, 63);
    for (int i = 0; i < 2200 && w2 < 2048; i++) begin
      nchk = vq[0];
      mm = nchk ? ((w2 % 1024) < 960 && (w2 % 64) == r)
                : 1'($urandom_range(0, 1));
      cyc(1, 0, 1, mm);
      if (nchk) w2++;
    end
    tests++;
    if (err0 !== 16'd30 || word0 !== 16'd2048) begin
      fails++;
      $display("FAIL window_counts: got err=%0d words=%0d want 30/2048",
               err0, word0);
    end
    tests++;
    if (halt0 !== 1'b0 || locked0 !== 1'b1) begin
      fails++;
      $display("FAIL window_nohalt: got halt=%b locked=%b want 0/1",
               halt0, locked0);
    end
    tests++;
    if (err1 !== 4'd15 || word1 !== 4'd15) begin
      fails++;
      $display("FAIL saturate: got err=%0d words=%0d want 15/15",
               err1, word1);
    end
    tests++;
    if (dv0 !== mv0 || dv1 !== mv1) begin
      fails++;
      $display("FAIL window_model: got %h/%h want %h/%h",
               dv0, dv1, mv0, mv1);
    end
  endtask

  task automatic test_lol();
    tests++;
    if (lol0 !== 8'd0) begin
      fails++;
      $display("FAIL lol_pre: got %0d want 0", lol0);
    end
    for (int i = 0; i < 8; i++) cyc(1, 0, 1, 1);
    tests++;
    if (LOL_EN) begin
      if (locked0 !== 1'b0 || state0 !== 2'd1 || lol0 !== 8'd1 ||
          lol1 !== 8'd1) begin
        fails++;
        $display("FAIL lol_drop: got locked=%b state=%0d lol=%0d want 0/1/1",
                 locked0, state0, lol0);
      end
    end else begin
      if (locked0 !== 1'b1 || state0 !== 2'd2 || lol0 !== 8'd0) begin
        fails++;
        $display("FAIL lol_none: got locked=%b state=%0d lol=%0d want 1/2/0",
                 locked0, state0, lol0);
      end
    end
    tests++;
    if (err0 !== 16'd38) begin
      fails++;
      $display("FAIL lol_errs: got %0d want 38", err0);
    end
  endtask

  task automatic test_halt();
    int e;
    bit prev, nchk, mm;
    e = 0;
    prev = 1'b0;
    cyc(1, 1, 1, 0);
    go_locked();
    tests++;
    if (locked0 !== 1'b1) begin
      fails++;
      $display("FAIL halt_lock: got locked=%b want 1", locked0);
    end
    for (int i = 0; i < 400 && e < 16; i++) begin
      nchk = vq[0];
      mm = nchk ? (!prev && $urandom_range(0, 2) == 0)
                : 1'($urandom_range(0, 1));
      cyc(1, 0, 1, mm);
      if (nchk) begin
        if (mm) e++;
        prev = mm;
      end
      tests++;
      if (halt0 !== (e >= 16)) begin
        fails++;
        $display("FAIL halt_timing: errs %0d got halt=%b", e, halt0);
      end
    end
    tests++;
    if (state0 !== 2'd3 || locked0 !== 1'b0 || err0 !== 16'd16) begin
      fails++;
      $display("FAIL halt_state: got state=%0d locked=%b err=%0d want 3/0/16",
               state0, locked0, err0);
    end
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1);
    tests++;
    if (halt0 !== 1'b1 || state0 !== 2'd3 || err0 !== 16'd16) begin
      fails++;
      $display("FAIL halt_sticky: got halt=%b state=%0d want 1/3",
               halt0, state0);
    end
    cyc(1, 1, 1, 0);
    tests++;
    if (halt0 !== 1'b0 || state0 !== 2'd1 || err0 !== 16'd0 ||
        word0 !== 16'd0) begin
      fails++;
      $display("FAIL halt_clear: got halt=%b state=%0d err=%0d want 0/1/0",
               halt0, state0, err0);
    end
  endtask

  task automatic test_async_reset();
    go_locked();
    for (int i = 0; i < 40 && mst[0] != 3; i++) cyc(1, 0, 1, i % 2 == 0);
    tests++;
    if (halt0 !== 1'b1) begin
      fails++;
      $display("FAIL arst_setup: got halt=%b want 1", halt0);
    end
    #2 arst_n = 1'b0;
    #1;
    tests++;
    if ({dv0, dv1} !== 64'd0) begin
      fails++;
      $display("FAIL arst_async: got %h/%h want 0", dv0, dv1);
    end
    model_reset();
    @(negedge clk);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 1);
    tests++;
    if ({dv0, dv1} !== 64'd0) begin
      fails++;
      $display("FAIL arst_hold: got %h/%h want 0", dv0, dv1);
    end
    arst_n = 1'b1;
    cyc(1, 0, 1, 0);
    tests++;
    if (state0 !== 2'd1 || dv0 !== mv0 || dv1 !== mv1) begin
      fails++;
      $display("FAIL arst_release: got %h want %h", dv0, mv0);
    end
  endtask

  task automatic test_clear_collision();
    cyc(1, 1, 1, 0);
    go_locked();
    for (int i = 0; i < 30; i++) cyc(1, 0, 1, i % 2 == 0);
    tests++;
    if (err0 !== 16'd15 || halt0 !== 1'b0) begin
      fails++;
      $display("FAIL coll_setup: got err=%0d halt=%b want 15/0", err0, halt0);
    end
    cyc(1, 1, 1, 1);
    tests++;
    if (halt0 !== 1'b0 || state0 !== 2'd1 || err0 !== 16'd0) begin
      fails++;
      $display("FAIL coll_clear: got halt=%b state=%0d err=%0d want 0/1/0",
               halt0, state0, err0);
    end
    cyc(0, 1, 1, 1);
    tests++;
    if (state0 !== 2'd0 || halt0 !== 1'b0) begin
      fails++;
      $display("FAIL clear_idle: got state=%0d want 0", state0);
    end
  endtask

  task automatic test_random();
    int mode;
    bit e, c, v, m;
    for (int p = 0; p < 20; p++) begin
      mode = $urandom_range(0, 3);
      for (int i = 0; i < 200; i++) begin
        e = $urandom_range(0, 99) != 0;
        c = $urandom_range(0, 299) == 0;
        v = $urandom_range(0, 7) != 0;
        case (mode)
          0:       m = 1'b0;
          1:       m = $urandom_range(0, 49) == 0;
          2:       m = $urandom_range(0, 2) == 0;
          default: m = $urandom_range(0, 9) != 0;
        endcase
        cyc(e, c, v, m);
        tests++;
        if (dv0 !== mv0 || dv1 !== mv1) begin
          fails++;
          $display("FAIL random_model: cyc %0d got %h/%h want %h/%h",
                   p * 200 + i, dv0, dv1, mv0, mv1);
        end
      end
    end
  endtask

  initial begin
    arst_n = 1'b0;
    enable = 1'b0;
    clear = 1'b0;
    din_valid = 1'b0;
    mismatch = 1'b0;
    @(negedge clk);
    test_reset();
    test_lock();
    test_window();
    test_lol();
    test_halt();
    test_async_reset();
    test_clear_collision();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
